// File: rtl/layer_sequencer_pkg.sv
// rtl/layer_sequencer_pkg.sv - shared layer-table types, widths and helpers
// Purpose: definitions shared by the config ROM, the layer sequencer and the
//          compute engine. No ports.
package layer_sequencer_pkg;

    localparam int ID_W     = 5;
    localparam int CH_W     = 11;
    localparam int DIM_W    = 8;
    localparam int WB_W     = 20;
    localparam int BB_W     = 12;
    localparam int TYPE_W   = 3;
    localparam int STRIDE_W = 2;

    localparam logic [TYPE_W-1:0] TYPE_CONV = 3'd0;
    localparam logic [TYPE_W-1:0] TYPE_DW   = 3'd1;
    localparam logic [TYPE_W-1:0] TYPE_PW   = 3'd2;
    localparam logic [TYPE_W-1:0] TYPE_AP   = 3'd3;
    localparam logic [TYPE_W-1:0] TYPE_FC   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        NEXT   = 3'd4
    } seq_state_t;

    // A table entry the engine cannot execute: unknown type, no input
    // channels, or a stride the datapath does not implement.
    function automatic logic cfg_is_bad(
        input logic [TYPE_W-1:0]   layer_type,
        input logic [CH_W-1:0]     cin,
        input logic [STRIDE_W-1:0] stride
    );
        return (layer_type > TYPE_FC) || (cin == '0) ||
               ((stride != 2'd1) && (stride != 2'd2));
    endfunction

    function automatic logic [DIM_W-1:0] out_dim(
        input logic [DIM_W-1:0]    dim,
        input logic [STRIDE_W-1:0] stride
    );
        return (stride == 2'd2) ? (dim >> 1) : dim;
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// rtl/layer_sequencer_if.sv - config ROM, config bundle and engine handshake
// Purpose: groups the signals between the sequencer and its ROM/engine.
// Ports (master = sequencer side):
//   rom_id            out  layer id to the combinational config ROM
//   rom_*             in   ROM answer for rom_id, valid the same cycle
//   cfg_*             out  registered configuration for the engine
//   eng_start         out  one-cycle engine launch
//   eng_done          in   one-cycle engine completion
//   buf_sel           out  ping-pong activation bank read by the engine
interface layer_sequencer_if;
    import layer_sequencer_pkg::*;

    logic [ID_W-1:0]     rom_id;
    logic [WB_W-1:0]     rom_w_base;
    logic [BB_W-1:0]     rom_b_base;
    logic [TYPE_W-1:0]   rom_type;
    logic [CH_W-1:0]     rom_cin;
    logic [CH_W-1:0]     rom_cout;
    logic [DIM_W-1:0]    rom_img_w;
    logic [DIM_W-1:0]    rom_img_h;
    logic [STRIDE_W-1:0] rom_stride;

    logic [WB_W-1:0]     cfg_w_base;
    logic [BB_W-1:0]     cfg_b_base;
    logic [TYPE_W-1:0]   cfg_type;
    logic [CH_W-1:0]     cfg_cin;
    logic [CH_W-1:0]     cfg_cout;
    logic [DIM_W-1:0]    cfg_img_w;
    logic [DIM_W-1:0]    cfg_img_h;
    logic [STRIDE_W-1:0] cfg_stride;
    logic [DIM_W-1:0]    cfg_out_w;
    logic [DIM_W-1:0]    cfg_out_h;

    logic                eng_start;
    logic                eng_done;
    logic                buf_sel;

    modport master (
        output rom_id,
        input  rom_w_base, rom_b_base, rom_type, rom_cin, rom_cout,
               rom_img_w, rom_img_h, rom_stride,
        output cfg_w_base, cfg_b_base, cfg_type, cfg_cin, cfg_cout,
               cfg_img_w, cfg_img_h, cfg_stride, cfg_out_w, cfg_out_h,
        output eng_start,
        input  eng_done,
        output buf_sel
    );

    modport slave (
        input  rom_id,
        output rom_w_base, rom_b_base, rom_type, rom_cin, rom_cout,
               rom_img_w, rom_img_h, rom_stride,
        input  cfg_w_base, cfg_b_base, cfg_type, cfg_cin, cfg_cout,
               cfg_img_w, cfg_img_h, cfg_stride, cfg_out_w, cfg_out_h,
        input  eng_start,
        output eng_done,
        input  buf_sel
    );

endinterface

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - walks the layer table and launches the engine once per layer
// Purpose: fetches each layer's config from the ROM, holds it stable for the
//          engine, pulses eng_start, waits for eng_done and swaps the
//          ping-pong activation buffers between layers.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a full run (accepted in IDLE only)
//   abort             cancel the run (highest priority outside IDLE)
//   sif               ROM / config / engine bundle (master side)
//   layer_idx         current layer id
//   busy              high outside IDLE
//   run_done          one-cycle pulse after the last layer completes
//   aborted           one-cycle pulse when an abort takes effect
//   cfg_err           sticky bad-config flag, cleared by the next start
//   layer_cycles      cycle count of the last completed layer
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int NUM_LAYERS = 29,
    parameter int CYC_W      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    layer_sequencer_if.master  sif,
    output logic [ID_W-1:0]    layer_idx,
    output logic               busy,
    output logic               run_done,
    output logic               aborted,
    output logic               cfg_err,
    output logic [CYC_W-1:0]   layer_cycles
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_LAYERS - 1);

    seq_state_t state, state_nxt;

    // Control strobes decoded from the state machine.
    logic clr_run, latch_cfg, set_err, clr_cnt, cnt_inc, cap_cycles;
    logic flip_buf, adv_layer, pulse_done, pulse_abort, launch;

    logic [CYC_W-1:0]    cyc_cnt;
    logic [CYC_W-1:0]    cyc_cnt_inc;
    logic                buf_sel_q;
    logic [WB_W-1:0]     w_base_q;
    logic [BB_W-1:0]     b_base_q;
    logic [TYPE_W-1:0]   type_q;
    logic [CH_W-1:0]     cin_q, cout_q;
    logic [DIM_W-1:0]    img_w_q, img_h_q, out_w_q, out_h_q;
    logic [STRIDE_W-1:0] stride_q;

    // Saturating increment shared by the running counter and the
    // "counter plus one" captured on eng_done.
    assign cyc_cnt_inc = (&cyc_cnt) ? cyc_cnt : cyc_cnt + CYC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_run     = 1'b0;
        latch_cfg   = 1'b0;
        set_err     = 1'b0;
        clr_cnt     = 1'b0;
        cnt_inc     = 1'b0;
        cap_cycles  = 1'b0;
        flip_buf    = 1'b0;
        adv_layer   = 1'b0;
        pulse_done  = 1'b0;
        pulse_abort = 1'b0;
        launch      = 1'b0;

        // Abort pre-empts every state action, including a same-cycle
        // eng_done and the launch pulse itself.
        if ((state != IDLE) && abort) begin
            state_nxt   = IDLE;
            pulse_abort = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = FETCH;
                        clr_run   = 1'b1;
                    end
                end
                FETCH: begin
                    latch_cfg = 1'b1;
                    if (cfg_is_bad(sif.rom_type, sif.rom_cin, sif.rom_stride)) begin
                        set_err   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = LAUNCH;
                    end
                end
                LAUNCH: begin
                    launch    = 1'b1;
                    clr_cnt   = 1'b1;
                    state_nxt = WAIT;
                end
                WAIT: begin
                    cnt_inc = 1'b1;
                    if (sif.eng_done) begin
                        cap_cycles = 1'b1;
                        state_nxt  = NEXT;
                    end
                end
                NEXT: begin
                    flip_buf = 1'b1;
                    if (layer_idx == LAST_ID) begin
                        pulse_done = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        adv_layer = 1'b1;
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_idx    <= '0;
            buf_sel_q    <= 1'b0;
            cfg_err      <= 1'b0;
            cyc_cnt      <= '0;
            layer_cycles <= '0;
            run_done     <= 1'b0;
            aborted      <= 1'b0;
            w_base_q     <= '0;
            b_base_q     <= '0;
            type_q       <= '0;
            cin_q        <= '0;
            cout_q       <= '0;
            img_w_q      <= '0;
            img_h_q      <= '0;
            stride_q     <= '0;
            out_w_q      <= '0;
            out_h_q      <= '0;
        end else begin
            run_done <= pulse_done;
            aborted  <= pulse_abort;

            if (clr_run) begin
                layer_idx <= '0;
                buf_sel_q <= 1'b0;
                cfg_err   <= 1'b0;
            end
            if (set_err) begin
                cfg_err <= 1'b1;
            end
            if (adv_layer) begin
                layer_idx <= layer_idx + ID_W'(1);
            end
            if (flip_buf) begin
                buf_sel_q <= ~buf_sel_q;
            end

            if (clr_cnt) begin
                cyc_cnt <= '0;
            end else if (cnt_inc) begin
                cyc_cnt <= cyc_cnt_inc;
            end
            if (cap_cycles) begin
                layer_cycles <= cyc_cnt_inc;
            end

            // The bad-config entry is latched too, so it can be inspected.
            if (latch_cfg) begin
                w_base_q <= sif.rom_w_base;
                b_base_q <= sif.rom_b_base;
                type_q   <= sif.rom_type;
                cin_q    <= sif.rom_cin;
                cout_q   <= sif.rom_cout;
                img_w_q  <= sif.rom_img_w;
                img_h_q  <= sif.rom_img_h;
                stride_q <= sif.rom_stride;
                out_w_q  <= out_dim(sif.rom_img_w, sif.rom_stride);
                out_h_q  <= out_dim(sif.rom_img_h, sif.rom_stride);
            end
        end
    end

    assign busy          = (state != IDLE);
    assign sif.rom_id    = layer_idx;
    assign sif.eng_start = launch;
    assign sif.buf_sel   = buf_sel_q;
    assign sif.cfg_w_base = w_base_q;
    assign sif.cfg_b_base = b_base_q;
    assign sif.cfg_type   = type_q;
    assign sif.cfg_cin    = cin_q;
    assign sif.cfg_cout   = cout_q;
    assign sif.cfg_img_w  = img_w_q;
    assign sif.cfg_img_h  = img_h_q;
    assign sif.cfg_stride = stride_q;
    assign sif.cfg_out_w  = out_w_q;
    assign sif.cfg_out_h  = out_h_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - directed self-checking bench for layer_sequencer
module tb_layer_sequencer;
    import layer_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        man_done = 1'b0;
    logic        auto_done = 1'b0;
    logic [4:0]  layer_idx;
    logic        busy, run_done, aborted, cfg_err;
    logic [31:0] layer_cycles;

    int total = 0;
    int bad = 0;

    int eng_lat = 5;
    int lat_cnt = 0;
    logic [4:0] bad_id = 5'd31;

    int cyc = 0;
    int n_start = 0;
    int n_run_done = 0;
    int n_abort = 0;
    int last_start_cyc = 0;
    int run_done_cyc = 0;

    logic [7:0]  cap_ow0 = '0;
    logic [10:0] cap_cout24 = '0;
    logic [10:0] cap_cout28 = '0;
    logic [2:0]  cap_type28 = '0;

    layer_sequencer_if ifc ();

    layer_sequencer #(.NUM_LAYERS(29), .CYC_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .sif          (ifc.master),
        .layer_idx    (layer_idx),
        .busy         (busy),
        .run_done     (run_done),
        .aborted      (aborted),
        .cfg_err      (cfg_err),
        .layer_cycles (layer_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  t;
        logic [10:0] cin;
        logic [10:0] cout;
        logic [7:0]  img;
        logic [1:0]  s;
    } row_t;

    // MobileNet v1 layer table: CONV, 13 DW/PW pairs, AP, FC.
    function automatic row_t rom_row(input logic [4:0] id);
        row_t r;
        case (id)
            5'd0:  r = '{3'd0, 11'd3,    11'd32,   8'd224, 2'd2};
            5'd1:  r = '{3'd1, 11'd32,   11'd32,   8'd112, 2'd1};
            5'd2:  r = '{3'd2, 11'd32,   11'd64,   8'd112, 2'd1};
            5'd3:  r = '{3'd1, 11'd64,   11'd64,   8'd112, 2'd2};
            5'd4:  r = '{3'd2, 11'd64,   11'd128,  8'd56,  2'd1};
            5'd5:  r = '{3'd1, 11'd128,  11'd128,  8'd56,  2'd1};
            5'd6:  r = '{3'd2, 11'd128,  11'd128,  8'd56,  2'd1};
            5'd7:  r = '{3'd1, 11'd128,  11'd128,  8'd56,  2'd2};
            5'd8:  r = '{3'd2, 11'd128,  11'd256,  8'd28,  2'd1};
            5'd9:  r = '{3'd1, 11'd256,  11'd256,  8'd28,  2'd1};
            5'd10: r = '{3'd2, 11'd256,  11'd256,  8'd28,  2'd1};
            5'd11: r = '{3'd1, 11'd256,  11'd256,  8'd28,  2'd2};
            5'd12: r = '{3'd2, 11'd256,  11'd512,  8'd14,  2'd1};
            5'd23: r = '{3'd1, 11'd512,  11'd512,  8'd14,  2'd2};
            5'd24: r = '{3'd2, 11'd512,  11'd1024, 8'd7,   2'd1};
            5'd25: r = '{3'd1, 11'd1024, 11'd1024, 8'd7,   2'd1};
            5'd26: r = '{3'd2, 11'd1024, 11'd1024, 8'd7,   2'd1};
            5'd27: r = '{3'd3, 11'd1024, 11'd1024, 8'd7,   2'd1};
            5'd28: r = '{3'd4, 11'd1024, 11'd1000, 8'd1,   2'd1};
            default: begin
                if (id >= 5'd13 && id <= 5'd22)
                    r = '{(id[0] ? 3'd1 : 3'd2), 11'd512, 11'd512, 8'd14, 2'd1};
                else
                    r = '{3'd7, 11'd0, 11'd0, 8'd0, 2'd0};
            end
        endcase
        return r;
    endfunction

    row_t cur_row;

    always_comb begin
        cur_row        = rom_row(ifc.rom_id);
        ifc.rom_type   = (ifc.rom_id == bad_id) ? 3'd5 : cur_row.t;
        ifc.rom_cin    = cur_row.cin;
        ifc.rom_cout   = cur_row.cout;
        ifc.rom_img_w  = cur_row.img;
        ifc.rom_img_h  = cur_row.img;
        ifc.rom_stride = cur_row.s;
        ifc.rom_w_base = (ifc.rom_id == 5'd27) ? 20'd0 : {3'd0, ifc.rom_id, 12'd0};
        ifc.rom_b_base = {1'b0, ifc.rom_id, 6'd0};
    end

    assign ifc.eng_done = auto_done | man_done;

    // Engine model: eng_done arrives eng_lat cycles after eng_start
    // (layer 13 takes two cycles longer so its layer_cycles is distinct).
    always @(posedge clk) begin
        if (ifc.eng_start)
            lat_cnt = eng_lat + ((layer_idx == 5'd13) ? 2 : 0);
        else if (lat_cnt > 0)
            lat_cnt = lat_cnt - 1;
        #1 auto_done = (lat_cnt == 1);
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (ifc.eng_start) begin
            n_start = n_start + 1;
            last_start_cyc = cyc;
        end
        if (run_done) begin
            n_run_done = n_run_done + 1;
            run_done_cyc = cyc;
        end
        if (aborted)
            n_abort = n_abort + 1;
    end

    always @(negedge clk) begin
        if (ifc.eng_start) begin
            if (layer_idx == 5'd0)  cap_ow0 = ifc.cfg_out_w;
            if (layer_idx == 5'd24) cap_cout24 = ifc.cfg_cout;
            if (layer_idx == 5'd28) begin
                cap_cout28 = ifc.cfg_cout;
                cap_type28 = ifc.cfg_type;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_launch(input logic [4:0] id);
        int n = 0;
        @(negedge clk);
        while (!(ifc.eng_start && layer_idx == id) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("wait_launch_timeout", 64'(n < 2000), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", 64'(n < 2000), 64'd1);
    endtask

    task automatic wait_run_done();
        int n = 0;
        @(negedge clk);
        while (!run_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("wait_run_done_timeout", 64'(n < 2000), 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
    endtask

    int b_st, b_rd, b_ab;
    logic [31:0] lc_before;

    initial begin
        // Reset state
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_layer_idx", 64'(layer_idx), 64'd0);
        check("rst_eng_start", 64'(ifc.eng_start), 64'd0);
        check("rst_cfg_cout", 64'(ifc.cfg_cout), 64'd0);
        check("rst_layer_cycles", 64'(layer_cycles), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // eng_done in IDLE is ignored
        b_st = n_start;
        man_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 man_done = 1'b0;
        @(negedge clk);
        check("idle_done_busy", 64'(busy), 64'd0);
        check("idle_done_cycles", 64'(layer_cycles), 64'd0);
        check("idle_done_starts", 64'(n_start - b_st), 64'd0);

        // Timing: start at T0, engine done at T5; eng_done also forced in FETCH/LAUNCH
        eng_lat = 3;
        pulse_start();
        for (int k = 1; k <= 8; k++) begin
            man_done = (k <= 2);
            @(negedge clk);
            check($sformatf("t%0d_eng_start", k), 64'(ifc.eng_start), 64'((k == 2) || (k == 8)));
            check($sformatf("t%0d_layer_idx", k), 64'(layer_idx), 64'((k >= 7) ? 1 : 0));
            @(posedge clk);
            #1;
        end
        man_done = 1'b0;
        b_ab = n_abort;
        pulse_abort();
        @(negedge clk);
        check("t_abort_pulse", 64'(aborted), 64'd1);
        check("t_abort_idle", 64'(busy), 64'd0);

        // Full run, latency 5, start pulsed during WAIT of layer 2
        eng_lat = 5;
        b_st = n_start;
        b_rd = n_run_done;
        pulse_start();
        wait_launch(5'd2);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("wait_start_busy", 64'(busy), 64'd1);
        check("wait_start_idx", 64'(layer_idx), 64'd2);
        wait_run_done();
        check("full_starts", 64'(n_start - b_st), 64'd29);
        check("full_buf_sel", 64'(ifc.buf_sel), 64'd1);
        check("full_layer_cycles", 64'(layer_cycles), 64'd5);
        check("full_layer_idx", 64'(layer_idx), 64'd28);
        check("full_busy", 64'(busy), 64'd0);
        check("full_ow0", 64'(cap_ow0), 64'd112);
        check("full_cout24", 64'(cap_cout24), 64'd1024);
        check("full_cout28", 64'(cap_cout28), 64'd1000);
        check("full_type28", 64'(cap_type28), 64'd4);
        check("full_hold_out_w", 64'(ifc.cfg_out_w), 64'd1);
        @(negedge clk);
        check("full_done_latency", 64'(run_done_cyc - last_start_cyc), 64'd7);
        check("full_run_done_pulse", 64'(run_done), 64'd0);
        check("full_run_done_count", 64'(n_run_done - b_rd), 64'd1);

        // Abort in layer 13 WAIT together with eng_done
        eng_lat = 4;
        b_rd = n_run_done;
        pulse_start();
        begin
            int n = 0;
            @(negedge clk);
            while (!(layer_idx == 5'd13 && ifc.eng_done) && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check("abort_wait_timeout", 64'(n < 2000), 64'd1);
        end
        lc_before = layer_cycles;
        check("abort_lc_before", 64'(lc_before), 64'd4);
        pulse_abort();
        @(negedge clk);
        check("abort_pulse", 64'(aborted), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_idx", 64'(layer_idx), 64'd13);
        check("abort_buf_sel", 64'(ifc.buf_sel), 64'd1);
        check("abort_layer_cycles", 64'(layer_cycles), 64'd4);
        repeat (3) @(negedge clk);
        check("abort_no_run_done", 64'(n_run_done - b_rd), 64'd0);
        check("abort_single_pulse", 64'(aborted), 64'd0);

        // Restart after abort begins at layer 0, bank 0
        pulse_start();
        @(negedge clk);
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_idx", 64'(layer_idx), 64'd0);
        check("restart_buf_sel", 64'(ifc.buf_sel), 64'd0);
        pulse_abort();

        // Bad config at layer 3
        bad_id = 5'd3;
        b_st = n_start;
        b_rd = n_run_done;
        pulse_start();
        wait_idle();
        check("err_flag", 64'(cfg_err), 64'd1);
        check("err_idx", 64'(layer_idx), 64'd3);
        check("err_type", 64'(ifc.cfg_type), 64'd5);
        check("err_starts", 64'(n_start - b_st), 64'd3);
        repeat (2) @(negedge clk);
        check("err_no_run_done", 64'(n_run_done - b_rd), 64'd0);
        check("err_sticky", 64'(cfg_err), 64'd1);
        bad_id = 5'd31;
        pulse_start();
        @(negedge clk);
        check("err_cleared", 64'(cfg_err), 64'd0);
        pulse_abort();

        // Asynchronous reset mid-WAIT
        eng_lat = 5;
        pulse_start();
        wait_launch(5'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_idx", 64'(layer_idx), 64'd0);
        check("arst_buf_sel", 64'(ifc.buf_sel), 64'd0);
        check("arst_cycles", 64'(layer_cycles), 64'd0);
        check("arst_cfg_cout", 64'(ifc.cfg_cout), 64'd0);
        check("arst_eng_start", 64'(ifc.eng_start), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        b_st = n_start;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("post_rst_idle", 64'(busy), 64'd0);
        check("post_rst_starts", 64'(n_start - b_st), 64'd0);
        check("post_rst_pulses", 64'({run_done, aborted}), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
